// File: rtl/mcseq_pkg.sv
// mcseq_pkg: enable codes, FSM states and program-entry layout shared by the
// program sequencer and its program memory.
package mcseq_pkg;

  localparam logic [1:0] EN_EXEC = 2'b00;
  localparam logic [1:0] EN_R0   = 2'b01;
  localparam logic [1:0] EN_R1   = 2'b10;
  localparam logic [1:0] EN_IR   = 2'b11;

  localparam int ENTRY_W = 10;
  localparam int EN_HI   = 9;
  localparam int EN_LO   = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  function automatic logic [1:0] entry_en(input logic [ENTRY_W-1:0] e);
    return e[EN_HI:EN_LO];
  endfunction

  function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
    return e[DATA_HI:DATA_LO];
  endfunction

endpackage

// File: rtl/mcseq_prog_mem.sv
// mcseq_prog_mem: DEPTH x 10 program store, synchronous write, asynchronous read.
// Deliberately unreset so a loaded program survives rst_n.
module mcseq_prog_mem
  import mcseq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mc_program_sequencer.sv
// mc_program_sequencer: replays a {enable,data} program into Main_Controller.
// MCSEQ_RESET_PREAMBLE_EN adds a 01/10/11 register-clear preamble before entry 0.
//   state    | meaning
//   ST_IDLE  | waiting for start; program writable
//   ST_PRE   | issuing the three clear cycles (preamble build only)
//   ST_ISSUE | fetching mem[idx] for the output register
//   ST_FIN   | run complete; done is registered out of this state
module mc_program_sequencer
  import mcseq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [ENTRY_W-1:0] prog_wdata,
  input  logic               start,
  input  logic [AW:0]        len,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      pc,
  output logic [7:0]         mc_data_in,
  output logic [1:0]         mc_enable
);

  state_e             state_q, state_d;
  logic [AW:0]        len_q, len_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [1:0]         en_q, en_d;
  logic [7:0]         data_q, data_d;
`ifdef MCSEQ_RESET_PREAMBLE_EN
  logic [1:0]         pre_q, pre_d;
`endif
  logic [ENTRY_W-1:0] rd_entry;
  logic               idle_ok, kill;
  logic [AW:0]        len_clamped, idx_next;

  // The FSM runs one cycle ahead of the registered outputs, so "idle" and
  // "running" as seen outside also look at the output registers.
  assign idle_ok     = (state_q == ST_IDLE) && !busy_q && !done_q;
  assign kill        = abort && (busy_q || state_q == ST_PRE || state_q == ST_ISSUE);
  assign len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign idx_next    = (AW+1)'(idx_q) + (AW+1)'(1);

  mcseq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (prog_we && idle_ok),
    .waddr_i (prog_addr),
    .wdata_i (prog_wdata),
    .raddr_i (idx_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pc_d    = '0;
    en_d    = EN_EXEC;
    data_d  = 8'h00;
`ifdef MCSEQ_RESET_PREAMBLE_EN
    pre_d   = pre_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && idle_ok) begin
          len_d = len_clamped;
          idx_d = '0;
`ifdef MCSEQ_RESET_PREAMBLE_EN
          pre_d   = 2'd0;
          state_d = ST_PRE;
`else
          state_d = (len_clamped == '0) ? ST_FIN : ST_ISSUE;
`endif
        end
      end
`ifdef MCSEQ_RESET_PREAMBLE_EN
      ST_PRE: begin
        busy_d = 1'b1;
        en_d   = pre_q + 2'd1;
        pre_d  = pre_q + 2'd1;
        if (pre_q == 2'd2) state_d = (len_q == '0) ? ST_FIN : ST_ISSUE;
      end
`endif
      ST_ISSUE: begin
        busy_d = 1'b1;
        pc_d   = idx_q;
        en_d   = entry_en(rd_entry);
        data_d = entry_data(rd_entry);
        idx_d  = idx_next[AW-1:0];
        if (idx_next == len_q) state_d = ST_FIN;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (kill) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pc_d    = '0;
      en_d    = EN_EXEC;
      data_d  = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
      en_q    <= EN_EXEC;
      data_q  <= 8'h00;
`ifdef MCSEQ_RESET_PREAMBLE_EN
      pre_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      en_q    <= en_d;
      data_q  <= data_d;
`ifdef MCSEQ_RESET_PREAMBLE_EN
      pre_q   <= pre_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pc         = pc_q;
  assign mc_enable  = en_q;
  assign mc_data_in = data_q;

endmodule

// File: tb/tb_mc_program_sequencer.sv
// tb_mc_program_sequencer: directed stimulus against a schedule-queue model of
// the sequencer, plus hand-computed literal checks on key cycles.
module tb_mc_program_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef MCSEQ_RESET_PREAMBLE_EN
  localparam int PRE_N = 3;
`else
  localparam int PRE_N = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [9:0]    prog_wdata = '0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [AW-1:0] pc;
  logic [7:0]    mc_data_in;
  logic [1:0]    mc_enable;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic [1:0]    en;
    logic [7:0]    data;
  } exp_t;

  localparam exp_t IDLE_E = '0;

  exp_t       cur = '0;
  exp_t       sched[$];
  logic [9:0] m_mem [DEPTH];

  mc_program_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .mc_data_in (mc_data_in),
    .mc_enable  (mc_enable)
  );

  always #5 clk = ~clk;

  // Model: a started run becomes a queue of per-cycle output tuples; each
  // edge pops the next one. Abort empties the queue, start/writes are only
  // accepted while nothing is queued and no busy/done cycle is showing.
  always @(posedge clk) begin
    bit   active, blocked;
    exp_t nxt;
    int   l;
    cyc++;
    if (!rst_n) begin
      sched.delete();
      cur = IDLE_E;
    end else begin
      active  = cur.busy || (sched.size() > 0 && sched[0].busy);
      blocked = cur.busy || cur.done || (sched.size() > 0);
      nxt     = (sched.size() > 0) ? sched.pop_front() : IDLE_E;
      if (prog_we && !blocked) m_mem[prog_addr] = prog_wdata;
      if (abort && active) begin
        sched.delete();
        nxt = IDLE_E;
      end else if (start && !blocked) begin
        l = (int'(len) > DEPTH) ? DEPTH : int'(len);
`ifdef MCSEQ_RESET_PREAMBLE_EN
        sched.push_back('{busy: 1'b1, done: 1'b0, pc: '0, en: 2'b01, data: 8'h00});
        sched.push_back('{busy: 1'b1, done: 1'b0, pc: '0, en: 2'b10, data: 8'h00});
        sched.push_back('{busy: 1'b1, done: 1'b0, pc: '0, en: 2'b11, data: 8'h00});
`endif
        for (int k = 0; k < l; k++)
          sched.push_back('{busy: 1'b1, done: 1'b0, pc: AW'(k),
                            en: m_mem[k][9:8], data: m_mem[k][7:0]});
        sched.push_back('{busy: 1'b0, done: 1'b1, pc: '0, en: 2'b00, data: 8'h00});
      end
      cur = nxt;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = rst_n ? cur : IDLE_E;
    checks++;
    if ({busy, done, pc, mc_enable, mc_data_in} !== e) begin
      errors++;
      $display("FAIL model cyc=%0d got busy=%b done=%b pc=%0d en=%b data=%h want busy=%b done=%b pc=%0d en=%b data=%h",
               cyc, busy, done, pc, mc_enable, mc_data_in, e.busy, e.done, e.pc, e.en, e.data);
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [9:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic go(input int l, output int s);
    start = 1'b1; len = (AW+1)'(l);
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_done(input string name, input int s, input int want);
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check_lit(name, 32'(cyc - s), 32'(want));
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) c++;
    end
  endtask

  initial begin
    int s, nd;
    logic [9:0] prog [4];
    prog = '{10'h1FF, 10'h200, 10'h32B, 10'h000};

    #2;
    check_lit("rst_busy", 32'(busy), 32'h0);
    check_lit("rst_done", 32'(done), 32'h0);
    check_lit("rst_pc",   32'(pc), 32'h0);
    check_lit("rst_en",   32'(mc_enable), 32'h0);
    check_lit("rst_data", 32'(mc_data_in), 32'h0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) wr(k, prog[k]);
    for (int k = 4; k < DEPTH; k++) wr(k, {2'(k), 8'(8'h40 + k)});

    // OR program
    go(4, s);
`ifdef MCSEQ_RESET_PREAMBLE_EN
    wait_cyc(s + 1);
    check_lit("pre0_en", 32'(mc_enable), 32'h1);
    check_lit("pre0_pc", 32'(pc), 32'h0);
    wait_cyc(s + 3);
    check_lit("pre2_en", 32'(mc_enable), 32'h3);
    check_lit("pre2_data", 32'(mc_data_in), 32'h0);
`endif
    wait_cyc(s + 1 + PRE_N);
    check_lit("or_e0", {22'h0, mc_enable, mc_data_in}, 32'h1FF);
    wait_cyc(s + 3 + PRE_N);
    check_lit("or_e2", {22'h0, mc_enable, mc_data_in}, 32'h32B);
    check_lit("or_pc2", 32'(pc), 32'h2);
    wait_done("or_done", s, 5 + PRE_N);
    tick();

    go(0, s);
    wait_done("len0_done", s, 1 + PRE_N);
    tick();

    go(31, s);
    wait_cyc(s + 16 + PRE_N);
    check_lit("len31_last", {18'h0, pc, mc_enable, mc_data_in}, 32'h3F4F);
    wait_done("len31_done", s, 17 + PRE_N);
    tick();

    // start and write while busy are dropped
    go(4, s);
    wait_cyc(s + 2);
    start = 1'b1; len = 5'd2;
    prog_we = 1'b1; prog_addr = 4'd2; prog_wdata = 10'h055;
    tick();
    start = 1'b0; prog_we = 1'b0;
    count_done(12, nd);
    check_lit("prot_done_once", 32'(nd), 32'h1);
    go(4, s);
    wait_cyc(s + 3 + PRE_N);
    check_lit("prot_e2", {22'h0, mc_enable, mc_data_in}, 32'h32B);
    wait_done("prot_done", s, 5 + PRE_N);
    tick();

    // abort during entry 1
    go(4, s);
    wait_cyc(s + 2 + PRE_N);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_lit("abort_out", {17'h0, busy, done, pc, mc_enable, mc_data_in}, 32'h0);
    count_done(10, nd);
    check_lit("abort_no_done", 32'(nd), 32'h0);

    // abort on the last issue cycle
    go(2, s);
    wait_cyc(s + 2 + PRE_N);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    count_done(10, nd);
    check_lit("abort_last_no_done", 32'(nd), 32'h0);

    // start with abort on the same edge in idle
    abort = 1'b1;
    go(3, s);
    abort = 1'b0;
    wait_done("start_abort_done", s, 4 + PRE_N);
    tick();

    // write on the start edge is visible to that run
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 10'h1A5;
    go(1, s);
    prog_we = 1'b0;
    wait_cyc(s + 1 + PRE_N);
    check_lit("wr_same_edge", {22'h0, mc_enable, mc_data_in}, 32'h1A5);
    wait_done("wr_same_done", s, 2 + PRE_N);
    tick();
    wr(0, 10'h1FF);

    // async reset mid replay, program survives
    go(8, s);
    wait_cyc(s + 3);
    rst_n = 1'b0;
    #2;
    check_lit("rst_mid_out", {17'h0, busy, done, pc, mc_enable, mc_data_in}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    go(4, s);
    wait_cyc(s + 1 + PRE_N);
    check_lit("rerun_e0", {22'h0, mc_enable, mc_data_in}, 32'h1FF);
    wait_cyc(s + 3 + PRE_N);
    check_lit("rerun_e2", {22'h0, mc_enable, mc_data_in}, 32'h32B);
    wait_done("rerun_done", s, 5 + PRE_N);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
